// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants for the UART transmit path: issue FSM state encodings and
// the default byte width / FIFO depth that the transmitter wrapper also uses.
package uart_tx_fifo_pkg;

    // Issue FSM state encodings.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    // Defaults shared with the transmitter wrapper.
    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// Generic synchronous FIFO: register-array storage, wrap-bit pointers and
// full/empty/count flags. Reads are combinational from the read pointer, so
// the consumer sees the head entry whenever empty is low. Kept free of any
// UART specifics so it can also serve a receive FIFO.
module uart_fifo_mem
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              push;
    logic              pop;

    // Flags from the wrap-bit pointers; count wraps naturally modulo 2^(ADDR_W+1).
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

    // A push while full is dropped even if a pop happens on the same edge.
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

    // Storage write; the array itself is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Pointer advance on accepted push / pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus issue FSM feeding a UART transmitter. The bus side pushes
// bytes freely; the FSM pops one byte per frame and paces itself on tx_busy.
// Optional sticky overflow flag (ovf / ovf_clr) when UART_TX_FIFO_OVF_EN is
// defined.
//
// Handshakes:
//   push side  - wr_en is a valid; !full is the ready. A byte transfers on any
//                clk edge where wr_en && !full. wr_en while full is dropped.
//   issue side - tx_start is a one-cycle valid carrying tx_data; the
//                transmitter acknowledges by raising tx_busy, and the next
//                byte is not issued until tx_busy has risen and fallen again.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              drained,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
`ifdef UART_TX_FIFO_OVF_EN
    input  logic              ovf_clr,
    output logic              ovf,
`endif
    output logic [1:0]        dbg_state
);

    logic [1:0]        state;
    logic              pop;
    logic [DATA_W-1:0] head_data;

    // Pop exactly when IDLE issues a byte; uses the registered empty flag, so a
    // byte pushed on this edge is only seen next cycle.
    assign pop = (state == ST_IDLE) && !empty && !tx_busy;

    assign drained   = empty && (state == ST_IDLE) && !tx_busy;
    assign dbg_state = state;

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Issue FSM: start one frame, wait for busy to rise, then for it to fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_data  <= head_data;
                        tx_start <= 1'b1;
                        state    <= ST_WAIT_BUSY;
                    end else begin
                        tx_start <= 1'b0;
                    end
                end
                ST_WAIT_BUSY: begin
                    tx_start <= 1'b0;
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    tx_start <= 1'b0;
                    if (!tx_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    // Sticky overflow on any push attempted while full; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small behavioural transmitter
// (10-bit frame, BIT_PERIOD cycles per bit) and a start-pulse monitor.
module tb_uart_tx_fifo;

    localparam int DATA_W     = 8;
    localparam int DEPTH      = 16;
    localparam int ADDR_W     = 4;
    localparam int BIT_PERIOD = 5;
    localparam int FRAME_CYC  = 10 * BIT_PERIOD;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              drained;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic [1:0]        dbg_state;
`ifdef UART_TX_FIFO_OVF_EN
    logic              ovf_clr;
    logic              ovf;
`endif

    logic              force_busy;
    logic              model_busy;
    int                model_cnt;
    logic              prev_start;
    int                start_cnt;

    int checks;
    int errors;

    logic [DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0] exp_q[$];

    assign tx_busy = force_busy | model_busy;

    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .drained   (drained),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
`ifdef UART_TX_FIFO_OVF_EN
        .ovf_clr   (ovf_clr),
        .ovf       (ovf),
`endif
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural transmitter: latches tx_data on a start, busy for one frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (model_busy) begin
            if (model_cnt == FRAME_CYC - 1) begin
                model_busy <= 1'b0;
            end
            model_cnt <= model_cnt + 1;
        end else if (tx_start) begin
            model_busy <= 1'b1;
            model_cnt  <= 0;
            got_q.push_back(tx_data);
        end
    end

    // Start-pulse monitor: every pulse is one cycle wide and issued while idle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = 1'b0;
        end else begin
            if (tx_start) begin
                start_cnt++;
                checks++;
                assert (tx_busy === 1'b0) else begin
                    errors++;
                    $error("FAIL start_while_busy: observed tx_busy=%0b expected 0", tx_busy);
                end
                checks++;
                assert (prev_start === 1'b0) else begin
                    errors++;
                    $error("FAIL start_width: observed start high 2 cycles expected 1");
                end
            end
            prev_start = tx_start;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver: one byte presented for exactly one clk edge; returns at a negedge.
    task automatic push(input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_drained(input int budget, input string tag);
        int n = 0;
        while (!drained && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, drained}, 32'd1);
    endtask

    // Scoreboard compare of transmitted bytes against the expected queue.
    task automatic check_stream(input string tag);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int base;
        int guard;
        checks     = 0;
        errors     = 0;
        start_cnt  = 0;
        prev_start = 1'b0;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        force_busy = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr    = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_empty",    {31'd0, empty},    32'd1);
        chk("rst_full",     {31'd0, full},     32'd0);
        chk("rst_count",    {27'd0, count},    32'd0);
        chk("rst_drained",  {31'd0, drained},  32'd1);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data",  {24'd0, tx_data},  32'd0);
        chk("rst_state",    {30'd0, dbg_state}, 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
        chk("rst_ovf",      {31'd0, ovf},      32'd0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte latency
        push(8'hA5);
        chk("t1_start_at_N",  {31'd0, tx_start}, 32'd0);
        chk("t1_count_at_N",  {27'd0, count},    32'd1);
        @(negedge clk);
        chk("t1_start_N1",    {31'd0, tx_start}, 32'd1);
        chk("t1_data_N1",     {24'd0, tx_data},  32'hA5);
        chk("t1_count_N1",    {27'd0, count},    32'd0);
        chk("t1_drained_N1",  {31'd0, drained},  32'd0);
        @(negedge clk);
        chk("t1_start_N2",    {31'd0, tx_start}, 32'd0);
        chk("t1_data_hold",   {24'd0, tx_data},  32'hA5);
        wait_drained(200, "t1_drained");
        exp_q.push_back(8'hA5);
        check_stream("t1_stream");

        // Three back-to-back pushes against the transmitter model
        base = start_cnt;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        wait_drained(1000, "t2_drained");
        chk("t2_starts", start_cnt - base, 32'd3);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        check_stream("t2_stream");

        // Fill past full with busy held high
        force_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push(8'h10 + 8'(i));
            if (i == 14) chk("t3_not_full_15", {31'd0, full}, 32'd0);
            if (i == 15) begin
                chk("t3_full_16",  {31'd0, full},  32'd1);
                chk("t3_count_16", {27'd0, count}, 32'd16);
            end
        end
        chk("t3_full_after_drop",  {31'd0, full},  32'd1);
        chk("t3_count_after_drop", {27'd0, count}, 32'd16);
`ifdef UART_TX_FIFO_OVF_EN
        chk("t3_ovf_set", {31'd0, ovf}, 32'd1);
        repeat (3) @(negedge clk);
        chk("t3_ovf_sticky", {31'd0, ovf}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", {31'd0, ovf}, 32'd0);
`endif
        force_busy = 1'b0;
        wait_drained(2000, "t3_drained");
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
        check_stream("t3_stream");

        // Fill to 15, simultaneous push/pop, then 40 bytes total for wrap
        force_busy = 1'b1;
        for (int i = 0; i < 15; i++) push(8'h40 + 8'(i));
        chk("t4_count_15", {27'd0, count}, 32'd15);
        force_busy = 1'b0;
        push(8'h4F);
        chk("t4_count_pushpop", {27'd0, count}, 32'd15);
        chk("t4_start_pushpop", {31'd0, tx_start}, 32'd1);
        for (int i = 16; i < 40; i++) begin
            guard = 0;
            while (full && guard < 400) begin
                @(negedge clk);
                guard++;
            end
            chk("t4_full_wait", {31'd0, full}, 32'd0);
            push(8'h40 + 8'(i));
        end
        wait_drained(5000, "t4_drained");
        for (int i = 0; i < 40; i++) exp_q.push_back(8'h40 + 8'(i));
        check_stream("t4_stream");

        // Async reset mid-frame with 5 bytes queued
        for (int i = 0; i < 6; i++) push(8'h80 + 8'(i));
        chk("t5_count_5", {27'd0, count}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_count", {27'd0, count},    32'd0);
        chk("t5_rst_empty", {31'd0, empty},    32'd1);
        chk("t5_rst_start", {31'd0, tx_start}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        base = start_cnt;
        repeat (100) @(negedge clk);
        chk("t5_no_restart", start_cnt - base, 32'd0);
        chk("t5_drained",    {31'd0, drained}, 32'd1);
        push(8'h77);
        wait_drained(200, "t5_new_drained");
        exp_q.push_back(8'h77);
        check_stream("t5_stream");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
